// File: rtl/ht_empty_ptr_if.sv
// Free-pointer handshake between the hash-table data pipeline (master) and the
// free-list storage (slave). Signal suffixes are given from the storage's point of view.
interface ht_empty_ptr_if #(
  parameter int A_WIDTH = 10
);
  // Handshake: next_empty_ptr_o is a show-ahead head. It is consumed on any clock edge
  // where next_empty_ptr_rd_ack_i and next_empty_ptr_val_o are both high.
  // add_empty_ptr_en_i is a push strobe that has no ready: one pointer per cycle,
  // and it is accepted unless the list is full with no ack in the same cycle.
  logic [A_WIDTH-1:0] next_empty_ptr_o;
  logic               next_empty_ptr_val_o;
  logic               next_empty_ptr_rd_ack_i;
  logic [A_WIDTH-1:0] add_empty_ptr_i;
  logic               add_empty_ptr_en_i;

  modport master (
    input  next_empty_ptr_o,
    input  next_empty_ptr_val_o,
    output next_empty_ptr_rd_ack_i,
    output add_empty_ptr_i,
    output add_empty_ptr_en_i
  );

  modport slave (
    output next_empty_ptr_o,
    output next_empty_ptr_val_o,
    input  next_empty_ptr_rd_ack_i,
    input  add_empty_ptr_i,
    input  add_empty_ptr_en_i
  );
endinterface

// File: rtl/ht_empty_ptr_storage.sv
// Free-list FIFO of data-table addresses. It fills itself with 0..D-1 after reset,
// then hands out pointers in FIFO order and takes returned pointers back.
module ht_empty_ptr_storage #(
  parameter int A_WIDTH = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ht_empty_ptr_if.slave      ptr_if,
  output logic               init_done_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               underflow_err_o,
  output logic               overflow_err_o,
  output logic               dbg_state_o
);

  localparam int D = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] FULL = (A_WIDTH + 1)'(D);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] mem [D];
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   cnt_q, cnt_d;
  logic [A_WIDTH-1:0] head_q, head_d;
  logic               val_q, val_d;
  logic               init_done_q, init_done_d;
  logic               uf_q, uf_d;
  logic               of_q, of_d;
  logic               wr_en;
  logic [A_WIDTH-1:0] wr_data;
  logic               do_ack;
  logic               full;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    uf_d        = uf_q;
    of_d        = of_q;
    wr_en       = 1'b0;
    wr_data     = wr_ptr_q;
    do_ack      = 1'b0;
    full        = (cnt_q == FULL);

    case (state_q)
      ST_INIT: begin
        // The write pointer doubles as the init counter: slot i receives pointer i.
        wr_en    = 1'b1;
        wr_data  = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (wr_ptr_q == '1) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      default: begin
        do_ack   = ptr_if.next_empty_ptr_rd_ack_i & val_q;
        uf_d     = uf_q | (ptr_if.next_empty_ptr_rd_ack_i & ~val_q);
        // When the list is full, a consuming ack frees the slot that this push reuses.
        wr_en    = ptr_if.add_empty_ptr_en_i & (~full | do_ack);
        of_d     = of_q | (ptr_if.add_empty_ptr_en_i & full & ~do_ack);
        wr_data  = ptr_if.add_empty_ptr_i;
        wr_ptr_d = wr_ptr_q + A_WIDTH'(wr_en);
        rd_ptr_d = rd_ptr_q + A_WIDTH'(do_ack);
        cnt_d    = cnt_q + (A_WIDTH + 1)'(wr_en) - (A_WIDTH + 1)'(do_ack);
      end
    endcase

    val_d  = (state_d == ST_READY) && (cnt_d != '0);
    // The head is read one cycle ahead. A pointer written to the new head slot in this
    // same cycle bypasses the memory, so it appears at the head without extra latency.
    head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      val_q       <= 1'b0;
      init_done_q <= 1'b0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      val_q       <= val_d;
      init_done_q <= init_done_d;
      uf_q        <= uf_d;
      of_q        <= of_d;
    end
  end

  assign ptr_if.next_empty_ptr_o     = head_q;
  assign ptr_if.next_empty_ptr_val_o = val_q;
  assign init_done_o                 = init_done_q;
  assign free_cnt_o                  = cnt_q;
  assign underflow_err_o             = uf_q;
  assign overflow_err_o              = of_q;
  assign dbg_state_o                 = state_q;

endmodule

// File: tb/tb_ht_empty_ptr_storage.sv
// Randomised and directed stimulus for the free-pointer list. A queue-based model of
// the list predicts each cycle's outputs, and a negedge monitor compares them with the DUT.
module tb_ht_empty_ptr_storage;
  localparam int AW = 3;
  localparam int D  = 8;
  localparam int W  = 2 * AW + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic [AW:0]   free_cnt;
  logic          uf_err;
  logic          of_err;
  logic          dbg_state;

  ht_empty_ptr_if #(.A_WIDTH(AW)) pif ();

  ht_empty_ptr_storage #(.A_WIDTH(AW)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .ptr_if          (pif),
    .init_done_o     (init_done),
    .free_cnt_o      (free_cnt),
    .underflow_err_o (uf_err),
    .overflow_err_o  (of_err),
    .dbg_state_o     (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: a queue of free pointers plus an init counter.
  int            init_cnt;
  bit            ready;
  logic [AW-1:0] mq[$];
  bit            m_uf;
  bit            m_of;

  function automatic logic [W-1:0] pack(input logic idone, input logic val,
                                        input logic [AW-1:0] ptr, input logic [AW:0] cnt,
                                        input logic uf, input logic of_f);
    return {idone, val, ptr, cnt, uf, of_f};
  endfunction

  task automatic model_reset();
    init_cnt = 0;
    ready    = 1'b0;
    mq.delete();
    m_uf     = 1'b0;
    m_of     = 1'b0;
  endtask

  task automatic model_edge(input bit a, input bit e, input logic [AW-1:0] p);
    bit had;
    bit was_full;
    bit acked;
    logic [AW-1:0] hd;
    if (!ready) begin
      mq.push_back(AW'(init_cnt));
      init_cnt++;
      if (init_cnt == D) ready = 1'b1;
    end else begin
      had      = (mq.size() != 0);
      was_full = (mq.size() == D);
      acked    = a && had;
      if (a && !had) m_uf = 1'b1;
      if (acked) void'(mq.pop_front());
      if (e) begin
        if (was_full && !acked) m_of = 1'b1;
        else mq.push_back(p);
      end
    end
    hd = (mq.size() != 0) ? mq[0] : '0;
    exp_q.push_back(pack(ready, ready && (mq.size() != 0), hd,
                         (AW + 1)'(mq.size()), m_uf, m_of));
  endtask

  task automatic step(input bit a, input bit e, input logic [AW-1:0] p);
    pif.next_empty_ptr_rd_ack_i = a;
    pif.add_empty_ptr_en_i      = e;
    pif.add_empty_ptr_i         = p;
    @(posedge clk);
    #1;
    model_edge(a, e, p);
  endtask

  task automatic rand_step();
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)));
  endtask

  task automatic check_reset_outputs(input string name);
    logic [W:0] got;
    got = {pack(init_done, pif.next_empty_ptr_val_o, pif.next_empty_ptr_o,
                free_cnt, uf_err, of_err), dbg_state};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s: outputs=%h expected all zero", name, got);
    end
  endtask

  // Monitor: every cycle out of reset, pop one prediction and compare it.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (rst_n && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = pack(init_done, pif.next_empty_ptr_val_o, pif.next_empty_ptr_o,
                 free_cnt, uf_err, of_err);
      if (!exp[W-2]) begin
        exp[W-3 -: AW] = '0;
        got[W-3 -: AW] = '0;
      end
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle_out t=%0t: got init=%b val=%b ptr=%0d cnt=%0d uf=%b of=%b exp init=%b val=%b ptr=%0d cnt=%0d uf=%b of=%b",
                 $time, got[W-1], got[W-2], got[W-3 -: AW], got[AW+2:2], got[1], got[0],
                 exp[W-1], exp[W-2], exp[W-3 -: AW], exp[AW+2:2], exp[1], exp[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    pif.next_empty_ptr_rd_ack_i = 1'b0;
    pif.add_empty_ptr_en_i      = 1'b0;
    pif.add_empty_ptr_i         = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // Initialisation, with random acks and adds that must be ignored
    for (int i = 0; i < D; i++) rand_step();

    // Overflow at a full list, then a legal add together with an ack at a full list
    step(1'b0, 1'b1, 3'd3);
    step(1'b1, 1'b1, 3'd3);

    // Drain completely, then one more ack to cause an underflow
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);

    // Add to an empty list (bypass), then FIFO order
    step(1'b0, 1'b1, 3'd5);
    step(1'b0, 1'b1, 3'd2);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);

    // Ack and add in the same cycle with one pointer free
    step(1'b0, 1'b1, 3'd4);
    step(1'b1, 1'b1, 3'd6);
    step(1'b0, 1'b0, '0);

    for (int i = 0; i < 300; i++) rand_step();

    // Mid-run reset after a fresh init and three acks
    rst_n = 1'b0;
    step(1'b0, 1'b0, '0);
    model_reset();
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    pif.next_empty_ptr_rd_ack_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 60; i++) rand_step();

    pif.next_empty_ptr_rd_ack_i = 1'b0;
    pif.add_empty_ptr_en_i      = 1'b0;
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ht_empty_ptr_storage.md
Name: ht_empty_ptr_storage

Overview:
- Free-list manager for the hash table data RAM: tracks which data-table addresses (ram_data_t entries) are unused.
- Hands out the next free pointer for INSERT and takes pointers back on DELETE.
- Sits beside the data-table command pipeline. Its empty flag is what produces INSERT_NOT_SUCCESS_TABLE_IS_FULL.
- After reset it self-initialises so every table address is free.

Parameters:
- A_WIDTH, 10, pointer width; equals the package TABLE_ADDR_WIDTH. Depth D = 2**A_WIDTH.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-low reset
- next_empty_ptr_o  out  A_WIDTH  head free pointer (show-ahead)
- next_empty_ptr_val_o  out  1  next_empty_ptr_o is valid (free list non-empty, init done)
- next_empty_ptr_rd_ack_i  in  1  consume current head pointer
- add_empty_ptr_i  in  A_WIDTH  pointer being returned to the free list
- add_empty_ptr_en_i  in  1  return strobe, one pointer per cycle
- init_done_o  out  1  initialisation complete
- free_cnt_o  out  A_WIDTH+1  number of free pointers, 0..D
- underflow_err_o  out  1  sticky: ack seen while val low
- overflow_err_o  out  1  sticky: add seen while free_cnt_o == D

Behaviour:
- Storage: circular FIFO, depth D, with write pointer, read pointer and count. Memory read latency is 1 cycle; a prefetch/bypass register provides show-ahead output.
- Reset (rst_i low, asynchronous):
  - all outputs 0; internal pointers and count 0; state INIT.
  - A reset asserted mid-operation discards all state, and re-initialisation follows.
- State INIT:
  - One write per clock: init counter i = 0..D-1 writes pointer value i.
  - rd_ack and add_en are ignored and do not set error flags.
  - free_cnt_o counts up with each write.
- INIT -> READY:
  - Taken on the edge that writes pointer D-1, i.e. D rising edges after reset release.
  - In the first READY cycle: init_done_o=1, free_cnt_o=D, next_empty_ptr_val_o=1, next_empty_ptr_o=0.
- State READY:
  - Allocation order is strict FIFO: pointers come out in the order they were written, starting 0,1,2,… after init.
  - next_empty_ptr_val_o = (free_cnt_o != 0), registered.
  - Ack in cycle N with val=1:
    - head is consumed.
    - In cycle N+1, next_empty_ptr_o shows the following FIFO entry.
    - free_cnt_o decrements.
    - val drops in N+1 if the count becomes 0.
  - Add in cycle N with free_cnt_o < D:
    - pointer is appended and free_cnt_o increments in N+1.
    - If the list was empty, in N+1 val=1 and next_empty_ptr_o = added pointer (bypass, no extra latency).
  - Simultaneous ack and add in the same cycle:
    - free_cnt_o unchanged.
    - If free_cnt_o was 1, in N+1 next_empty_ptr_o = added pointer and val stays 1.
  - Ack with val=0: no state change; underflow_err_o=1 from N+1.
  - Add with free_cnt_o==D: pointer dropped, no state change, overflow_err_o=1 from N+1. An add simultaneous with a valid ack at count D is legal and not an overflow.
  - Error flags stay set until reset.
  - The block does not check for duplicate returns of the same pointer; that is the caller's responsibility.
- Pointer arithmetic:
  - Read and write pointers are A_WIDTH bits and wrap modulo D naturally.
  - Count is A_WIDTH+1 bits, saturating is never needed given the guards above.
- READY never returns to INIT except through reset.

Test Plan:
- A_WIDTH=3, release reset -> init_done_o rises after 8 clocks; free_cnt_o=8, val=1, ptr=0; acks/adds driven during INIT have no effect and raise no errors.
- 8 back-to-back acks -> ptr sequence 0,1,…,7 one per cycle; after last, val=0, free_cnt_o=0; a 9th ack -> underflow_err_o=1, count stays 0.
- From empty, add ptr 5 -> next cycle val=1, ptr=5, free_cnt_o=1; then add 2, ack, ack -> ptrs 5 then 2 in order, count ends 0.
- free_cnt_o=1 (head=4), simultaneous ack + add 6 -> next cycle ptr=6, val=1, count=1; no error.
- After init (count=8), add 3 -> overflow_err_o=1, count=8, head still 0; the same add together with an ack -> no overflow, count=8, head=1, 3 appended at tail.
- Reset asserted mid-sequence after 3 acks -> outputs 0 immediately (asynchronous); after release and 8 clocks, init_done_o=1, ptr=0, count=8, error flags clear.
